// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel/line counters, blank, delayed hs/vs and pacing strobes.
// Optional feature: define VGA_FRAME_COUNTER_EN to add the 16-bit frame_cnt output.
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_DLY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_end,
  output logic        frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT_W  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
  // Sync window edges can reach 1024, so they are compared at 11 bits.
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_err
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
  end
  if (SYNC_DLY < 0 || SYNC_DLY > 3) begin : g_dly_err
    $error("vga_timing_gen: SYNC_DLY must be in 0..3");
  end

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hs_raw;
  logic       vs_raw;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    x_nxt = DrawX + 10'd1;
    y_nxt = DrawY;
    if (DrawX == H_MAX) begin
      x_nxt = '0;
      y_nxt = (DrawY == V_MAX) ? 10'd0 : DrawY + 10'd1;
    end
  end

  // Strobes are decoded from the next count so they line up with DrawX/DrawY.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= H_MAX;
      DrawY       <= V_MAX;
      blank       <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank       <= (x_nxt < H_ACT_W) && (y_nxt < V_ACT_W);
      line_end    <= (x_nxt == H_MAX);
      frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
    end
  end

  assign hs_raw = !(({1'b0, DrawX} >= HS_START) && ({1'b0, DrawX} < HS_END));
  assign vs_raw = !(({1'b0, DrawY} >= VS_START) && ({1'b0, DrawY} < VS_END));

  if (SYNC_DLY == 0) begin : g_nodly
    // Force the idle level while in reset even if the reset count sits inside a sync window.
    assign hs = hs_raw | ~reset_n;
    assign vs = vs_raw | ~reset_n;
  end else begin : g_dly
    logic [SYNC_DLY-1:0] hs_pipe;
    logic [SYNC_DLY-1:0] vs_pipe;

    // Stages reset to the inactive (high) sync level so no false pulse leaves the pipe.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe <= '1;
        vs_pipe <= '1;
      end else begin
        hs_pipe[0] <= hs_raw;
        vs_pipe[0] <= vs_raw;
        for (int i = 1; i < SYNC_DLY; i++) begin
          hs_pipe[i] <= hs_pipe[i-1];
          vs_pipe[i] <= vs_pipe[i-1];
        end
      end
    end

    assign hs = hs_pipe[SYNC_DLY-1];
    assign vs = vs_pipe[SYNC_DLY-1];
  end

`ifdef VGA_FRAME_COUNTER_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if ((x_nxt == 10'd0) && (y_nxt == 10'd0)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default-timing instance (SYNC_DLY=0) and a
// small-raster instance (SYNC_DLY=2) run side by side so whole frames fit in a short run.
`timescale 1ns/1ps

module tb_vga_timing_gen;

  // Small raster: H_TOTAL = 25 (sync 18..21), V_TOTAL = 19 (sync 14..15), frame = 475 cycles.
  localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int S_VA = 12, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_DLY = 2;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_FRAME = S_HT * (S_VA + S_VFP + S_VS + S_VBP);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       le;
    logic       fs;
  } exp_t;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_blank, d_hs, d_vs, d_le, d_fs;
  logic       s_blank, s_hs, s_vs, s_le, s_fs;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] d_fc, s_fc;
`endif

  exp_t q_d[$];
  exp_t q_s[$];
  int   total = 0;
  int   bad   = 0;
  int   n     = -1;  // edges since reset release; -1 while in reset

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen #(.SYNC_DLY(0)) u_dflt (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (d_x),
    .DrawY       (d_y),
    .blank       (d_blank),
    .hs          (d_hs),
    .vs          (d_vs),
    .line_end    (d_le),
    .frame_start (d_fs)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_cnt   (d_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_DLY(S_DLY)
  ) u_small (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .blank       (s_blank),
    .hs          (s_hs),
    .vs          (s_vs),
    .line_end    (s_le),
    .frame_start (s_fs)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_cnt   (s_fc)
`endif
  );

  // Expected outputs after edge k of a free-running raster, computed from the edge count.
  function automatic exp_t model(input int k, input int ha, input int hfp, input int hsy,
                                 input int hbp, input int va, input int vfp, input int vsy,
                                 input int vbp, input int dly);
    int   ht, vt, x, y, m, xm, ym;
    exp_t e;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    if (k < 0) begin
      e = '{x: 10'(ht - 1), y: 10'(vt - 1), blank: 1'b0, hs: 1'b1, vs: 1'b1, le: 1'b0, fs: 1'b0};
      return e;
    end
    x = k % ht;
    y = (k / ht) % vt;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.blank = (x < ha) && (y < va);
    e.le    = (x == ht - 1);
    e.fs    = (x == 0) && (y == 0);
    m = k - dly;
    if (m < 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      xm = m % ht;
      ym = (m / ht) % vt;
      e.hs = !((xm >= ha + hfp) && (xm < ha + hfp + hsy));
      e.vs = !((ym >= va + vfp) && (ym < va + vfp + vsy));
    end
    return e;
  endfunction

  // One clock: push expectations at the edge, pop and score at the following negedge.
  task automatic step();
    exp_t a, e;
    @(posedge vga_clk);
    if (reset_n) n++;
    q_d.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33, 0));
    q_s.push_back(model(n, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_DLY));
    @(negedge vga_clk);
    a = {d_x, d_y, d_blank, d_hs, d_vs, d_le, d_fs};
    e = q_d.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL sb_dflt n=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b le=%b fs=%b exp x=%0d y=%0d blank=%b hs=%b vs=%b le=%b fs=%b",
               n, a.x, a.y, a.blank, a.hs, a.vs, a.le, a.fs, e.x, e.y, e.blank, e.hs, e.vs, e.le, e.fs);
    end
    a = {s_x, s_y, s_blank, s_hs, s_vs, s_le, s_fs};
    e = q_s.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL sb_small n=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b le=%b fs=%b exp x=%0d y=%0d blank=%b hs=%b vs=%b le=%b fs=%b",
               n, a.x, a.y, a.blank, a.hs, a.vs, a.le, a.fs, e.x, e.y, e.blank, e.hs, e.vs, e.le, e.fs);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge vga_clk);
    total++;
    if ({d_x, d_y, d_hs, d_vs, d_blank, d_le, d_fs} !== {10'd799, 10'd524, 5'b11000}) begin
      bad++;
      $display("FAIL reset_dflt got x=%0d y=%0d hs=%b vs=%b blank=%b le=%b fs=%b exp 799 524 1 1 0 0 0",
               d_x, d_y, d_hs, d_vs, d_blank, d_le, d_fs);
    end
    total++;
    if ({s_x, s_y, s_hs, s_vs, s_blank, s_le, s_fs} !== {10'd24, 10'd18, 5'b11000}) begin
      bad++;
      $display("FAIL reset_small got x=%0d y=%0d hs=%b vs=%b blank=%b le=%b fs=%b exp 24 18 1 1 0 0 0",
               s_x, s_y, s_hs, s_vs, s_blank, s_le, s_fs);
    end
`ifdef VGA_FRAME_COUNTER_EN
    total++;
    if (s_fc !== 16'd0) begin
      bad++;
      $display("FAIL reset_frame_cnt got %0d exp 0", s_fc);
    end
`endif
    reset_n = 1'b1;
    n = -1;
    step();
    total++;
    if ({d_x, d_y, d_blank, d_fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL first_edge got x=%0d y=%0d blank=%b fs=%b exp 0 0 1 1", d_x, d_y, d_blank, d_fs);
    end
  endtask

  task automatic test_line_timing();
    int hs_lo = 0, hs_first = -1, hs_last = -1, bl_hi0 = 0, bl_hi1 = 0, le_cnt = 0, le_bad = 0;
    while (n < 2 * 800 - 1) begin
      step();
      if (d_y == 10'd1) begin
        if (!d_hs) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(d_x);
          hs_last = int'(d_x);
        end
        if (d_blank) bl_hi1++;
      end
      if (d_y == 10'd0 && d_blank) bl_hi0++;
      if (d_le) begin
        le_cnt++;
        if (d_x != 10'd799) le_bad++;
      end
    end
    total++;
    if (hs_lo != 96 || hs_first != 656 || hs_last != 751) begin
      bad++;
      $display("FAIL hs_window got width=%0d first=%0d last=%0d exp 96 656 751", hs_lo, hs_first, hs_last);
    end
    // Line 0 is observed from DrawX=1 on, since DrawX=0 was scored at the first edge.
    total++;
    if (bl_hi0 != 639 || bl_hi1 != 640) begin
      bad++;
      $display("FAIL blank_line got line0=%0d line1=%0d exp 639 640", bl_hi0, bl_hi1);
    end
    total++;
    if (le_cnt != 2 || le_bad != 0) begin
      bad++;
      $display("FAIL line_end got count=%0d misplaced=%0d exp 2 0", le_cnt, le_bad);
    end
  endtask

  task automatic test_frame_timing();
    int k = 0, n_a, n_b = -1, vs_lo = 0, vbl_bad = 0;
    while (!s_fs && k < 600) begin step(); k++; end
    n_a = n;
    k = 0;
    do begin
      step();
      k++;
      if (!s_vs) vs_lo++;
      if (s_y >= 10'(S_VA) && s_blank) vbl_bad++;
    end while (!s_fs && k < 600);
    if (s_fs) n_b = n;
    total++;
    if (n_b - n_a != S_FRAME) begin
      bad++;
      $display("FAIL frame_period got %0d exp %0d", n_b - n_a, S_FRAME);
    end
    total++;
    if (vs_lo != S_VS * S_HT) begin
      bad++;
      $display("FAIL vs_width got %0d exp %0d", vs_lo, S_VS * S_HT);
    end
    total++;
    if (vbl_bad != 0) begin
      bad++;
      $display("FAIL vblank_blank got %0d visible cycles in vblank exp 0", vbl_bad);
    end
  endtask

  task automatic test_sync_delay();
    int k = 0, n0, n1;
    while (s_x != 10'd18 && k < 100) begin step(); k++; end
    n0 = n;
    k = 0;
    while (s_hs && k < 10) begin step(); k++; end
    n1 = n;
    total++;
    if (n1 - n0 != 2 || s_hs !== 1'b0) begin
      bad++;
      $display("FAIL hs_delay got %0d cycles (hs=%b) exp 2", n1 - n0, s_hs);
    end
    k = 0;
    while (!(s_x == 10'd0 && s_y == 10'd14) && k < 600) begin step(); k++; end
    n0 = n;
    k = 0;
    while (s_vs && k < 10) begin step(); k++; end
    n1 = n;
    total++;
    if (n1 - n0 != 2 || s_vs !== 1'b0) begin
      bad++;
      $display("FAIL vs_delay got %0d cycles (vs=%b) exp 2", n1 - n0, s_vs);
    end
  endtask

  task automatic test_mid_frame_reset();
    int k = 0;
    while (!(s_x == 10'd10 && s_y == 10'd7) && k < 600) begin step(); k++; end
    total++;
    if (!(s_x == 10'd10 && s_y == 10'd7)) begin
      bad++;
      $display("FAIL mid_wait got x=%0d y=%0d exp 10 7", s_x, s_y);
    end
    #5 reset_n = 1'b0;
    #1;
    total++;
    if ({s_x, s_y, s_hs, s_vs, s_blank, s_le, s_fs} !== {10'd24, 10'd18, 5'b11000}) begin
      bad++;
      $display("FAIL async_reset_small got x=%0d y=%0d hs=%b vs=%b blank=%b le=%b fs=%b exp 24 18 1 1 0 0 0",
               s_x, s_y, s_hs, s_vs, s_blank, s_le, s_fs);
    end
    total++;
    if ({d_x, d_y, d_hs, d_vs, d_blank, d_le, d_fs} !== {10'd799, 10'd524, 5'b11000}) begin
      bad++;
      $display("FAIL async_reset_dflt got x=%0d y=%0d hs=%b vs=%b blank=%b le=%b fs=%b exp 799 524 1 1 0 0 0",
               d_x, d_y, d_hs, d_vs, d_blank, d_le, d_fs);
    end
    n = -1;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    total++;
    if ({s_x, s_y, s_fs, d_x, d_y, d_fs} !== {10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b1}) begin
      bad++;
      $display("FAIL restart got small=(%0d,%0d,fs=%b) dflt=(%0d,%0d,fs=%b) exp (0,0,1) twice",
               s_x, s_y, s_fs, d_x, d_y, d_fs);
    end
    repeat (30) step();
  endtask

`ifdef VGA_FRAME_COUNTER_EN
  task automatic test_frame_counter();
    int k = 0;
    while (n < 3 * S_FRAME - 1) step();
    total++;
    if (s_fc !== 16'd3 || d_fc !== 16'd1) begin
      bad++;
      $display("FAIL frame_cnt_3 got small=%0d dflt=%0d exp 3 1", s_fc, d_fc);
    end
    while (n % S_FRAME != 100) step();
    force u_small.frame_cnt = 16'hFFFF;
    #1;
    release u_small.frame_cnt;
    step();
    total++;
    if (s_fc !== 16'hFFFF) begin
      bad++;
      $display("FAIL frame_cnt_hold got %h exp ffff", s_fc);
    end
    while (!s_fs && k < 600) begin step(); k++; end
    total++;
    if (s_fc !== 16'd0 || !s_fs) begin
      bad++;
      $display("FAIL frame_cnt_wrap got %h (fs=%b) exp 0000", s_fc, s_fs);
    end
    step();
    total++;
    if (s_fc !== 16'd0) begin
      bad++;
      $display("FAIL frame_cnt_after_wrap got %h exp 0000", s_fc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_sync_delay();
    test_mid_frame_reset();
`ifdef VGA_FRAME_COUNTER_EN
    test_frame_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
